// File: rtl/sound_latch_irq.sv
// Sound-command latch between the main CPU and the Z80 sound CPU, merged with the
// YM2151 interrupt into a single Z80 INT line and an IM0 RST vector.
module sound_latch_irq (
    input  logic       clk,
    input  logic       reset,
    input  logic       snd_wr,
    input  logic [7:0] cpu_din,
    input  logic       z80_ack_wr,
    input  logic       ym_irq_n,
    input  logic       z80_iack,
    output logic [7:0] latch_dout,
    output logic [7:0] vector_dout,
    output logic       z80_int_n,
    output logic       pending,
    output logic       overrun
);

    // Strobe history and synchroniser state
    logic snd_wr_q;
    logic ack_q;
    logic iack_q;
    logic rst_q;
    logic ym_meta;
    logic ym_s;

    logic       wr_ev;
    logic       ack_ev;
    logic       iack_ev;
    logic [7:0] vector;

    // rst_q masks the first cycle after reset, so a strobe still held high across
    // reset release is taken as already seen and must fall before it can fire.
    assign wr_ev   = snd_wr     & ~snd_wr_q & ~rst_q;
    assign ack_ev  = z80_ack_wr & ~ack_q    & ~rst_q;
    assign iack_ev = z80_iack   & ~iack_q   & ~rst_q;

    // RST 18h for the sound command, RST 28h for the YM, 0xCF when both are set
    assign vector    = {2'b11, ~pending, ~ym_s, 4'b1111};
    assign z80_int_n = ~(pending | ym_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            snd_wr_q    <= 1'b0;
            ack_q       <= 1'b0;
            iack_q      <= 1'b0;
            rst_q       <= 1'b1;
            ym_meta     <= 1'b0;
            ym_s        <= 1'b0;
            latch_dout  <= 8'h00;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            vector_dout <= 8'hFF;
        end else begin
            snd_wr_q <= snd_wr;
            ack_q    <= z80_ack_wr;
            iack_q   <= z80_iack;
            rst_q    <= 1'b0;
            ym_meta  <= ~ym_irq_n;
            ym_s     <= ym_meta;

            // A write in the same cycle as an ack wins; the ack is dropped.
            if (wr_ev) begin
                latch_dout <= cpu_din;
                pending    <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                end
            end else if (ack_ev) begin
                pending <= 1'b0;
            end

            // Vector follows the live value except while an acknowledge cycle holds it.
            if (!z80_iack || iack_ev) begin
                vector_dout <= vector;
            end
        end
    end

endmodule

// File: tb/tb_sound_latch_irq.sv
// Randomized scoreboard bench for sound_latch_irq: the driver pushes the expected
// post-edge outputs from a behavioural model, a monitor pops and compares every cycle.
module tb_sound_latch_irq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       snd_wr = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       z80_ack_wr = 1'b0;
    logic       ym_irq_n = 1'b1;
    logic       z80_iack = 1'b0;
    logic [7:0] latch_dout;
    logic [7:0] vector_dout;
    logic       z80_int_n;
    logic       pending;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    // {latch, vector, pending, overrun, int_n}
    logic [18:0] exp_q[$];

    // Behavioural model state
    logic [7:0] m_latch = 8'h00;
    logic [7:0] m_vec = 8'hFF;
    bit         m_pend = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_ym_a = 1'b0;
    bit         m_ym_b = 1'b0;
    bit         prev_w = 1'b1;
    bit         prev_a = 1'b1;
    bit         prev_i = 1'b1;

    sound_latch_irq dut (
        .clk        (clk),
        .reset      (reset),
        .snd_wr     (snd_wr),
        .cpu_din    (cpu_din),
        .z80_ack_wr (z80_ack_wr),
        .ym_irq_n   (ym_irq_n),
        .z80_iack   (z80_iack),
        .latch_dout (latch_dout),
        .vector_dout(vector_dout),
        .z80_int_n  (z80_int_n),
        .pending    (pending),
        .overrun    (overrun)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs at the falling edge and predict the result
    // of the following rising edge. After reset a strobe counts as "previously high".
    task automatic tick(input bit r, input bit w, input logic [7:0] d,
                        input bit a, input bit i, input bit y);
        logic [7:0] live;
        @(negedge clk);
        reset      = r;
        snd_wr     = w;
        cpu_din    = d;
        z80_ack_wr = a;
        z80_iack   = i;
        ym_irq_n   = y;
        if (r) begin
            m_latch = 8'h00;
            m_pend  = 1'b0;
            m_ovr   = 1'b0;
            m_vec   = 8'hFF;
            m_ym_a  = 1'b0;
            m_ym_b  = 1'b0;
            prev_w  = 1'b1;
            prev_a  = 1'b1;
            prev_i  = 1'b1;
        end else begin
            live = 8'hFF;
            if (m_pend) live = live - 8'h20;
            if (m_ym_b) live = live - 8'h10;
            if (!i || !prev_i) m_vec = live;
            if (w && !prev_w) begin
                if (m_pend) m_ovr = 1'b1;
                m_latch = d;
                m_pend  = 1'b1;
            end else if (a && !prev_a) begin
                m_pend = 1'b0;
            end
            m_ym_b = m_ym_a;
            m_ym_a = !y;
            prev_w = w;
            prev_a = a;
            prev_i = i;
        end
        exp_q.push_back({m_latch, m_vec, m_pend, m_ovr, ~(m_pend | m_ym_b)});
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always begin : monitor
        logic [18:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("latch_dout", latch_dout, e[18:11]);
            chk("vector_dout", vector_dout, e[10:3]);
            chk("pending", {7'd0, pending}, {7'd0, e[2]});
            chk("overrun", {7'd0, overrun}, {7'd0, e[1]});
            chk("z80_int_n", {7'd0, z80_int_n}, {7'd0, e[0]});
        end
    end

    initial begin : stim
        bit         w;
        bit         a;
        bit         i;
        bit         y;
        bit         r;
        logic [7:0] d;
        int         n;

        repeat (3) tick(1, 0, 8'h00, 0, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);

        // Single held write, then ack
        repeat (3) tick(0, 1, 8'h5A, 0, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);
        tick(0, 0, 8'h00, 1, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);

        // Overrun with write/ack collision
        tick(0, 1, 8'h11, 0, 0, 1);
        tick(0, 0, 8'h11, 0, 0, 1);
        tick(0, 1, 8'h22, 1, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);
        tick(0, 0, 8'h00, 1, 0, 1);
        tick(0, 0, 8'h00, 0, 0, 1);

        // YM combined with a pending command
        tick(0, 1, 8'h33, 0, 0, 1);
        tick(0, 0, 8'h00, 0, 0, 1);
        repeat (4) tick(0, 0, 8'h00, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 0, 0);
        repeat (3) tick(0, 0, 8'h00, 0, 0, 0);
        repeat (4) tick(0, 0, 8'h00, 0, 0, 1);

        // Vector freeze across an ack during iack
        tick(0, 1, 8'h44, 0, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 1, 1);
        tick(0, 0, 8'h00, 1, 1, 1);
        repeat (3) tick(0, 0, 8'h00, 0, 1, 1);
        repeat (3) tick(0, 0, 8'h00, 0, 0, 1);

        // Reset mid-handshake with snd_wr held high across release
        tick(0, 1, 8'h55, 0, 0, 1);
        tick(0, 0, 8'h55, 0, 0, 1);
        tick(0, 1, 8'h66, 0, 1, 1);
        repeat (3) tick(1, 1, 8'h77, 0, 1, 0);
        repeat (3) tick(0, 1, 8'h77, 0, 1, 1);
        repeat (2) tick(0, 0, 8'h00, 0, 0, 1);
        tick(0, 1, 8'h88, 0, 0, 1);
        tick(0, 0, 8'h00, 0, 0, 1);

        // Randomized traffic with held strobes and occasional resets
        w = 0; a = 0; i = 0; y = 1; d = 8'h00;
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) w = ~w;
            if ($urandom_range(0, 4) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) i = ~i;
            if ($urandom_range(0, 11) == 0) y = ~y;
            if (!w) d = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 99) == 0);
            tick(r, w, d, a, i, y);
        end
        tick(0, 0, 8'h00, 0, 0, 1);

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sound_latch_irq.md
SOUND_LATCH_IRQ -- requirements
Module: sound_latch_irq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port snd_wr, input, 1 bit: SND write strobe from the I/O decoder; level, active-high, may stay high for multiple cycles.
REQ-004 The block SHALL have the port cpu_din, input, 8 bits: main-CPU data bus low byte, valid while snd_wr is high.
REQ-005 The block SHALL have the port z80_ack_wr, input, 1 bit: Z80 write strobe to the latch-acknowledge port; level, active-high.
REQ-006 The block SHALL have the port ym_irq_n, input, 1 bit: YM2151 interrupt, active-low, asynchronous to clk.
REQ-007 The block SHALL have the port z80_iack, input, 1 bit: Z80 interrupt-acknowledge cycle (M1 and IORQ both active); level, active-high.
REQ-008 The block SHALL have the port latch_dout, output, 8 bits: held sound command byte, read by the Z80.
REQ-009 The block SHALL have the port vector_dout, output, 8 bits: IM0 RST opcode driven during the interrupt-acknowledge cycle.
REQ-010 The block SHALL have the port z80_int_n, output, 1 bit: Z80 INT, active-low.
REQ-011 The block SHALL have the port pending, output, 1 bit: command written and not yet acknowledged.
REQ-012 The block SHALL have the port overrun, output, 1 bit: sticky flag, set when a command is overwritten before acknowledge.

Function
REQ-013 The block SHALL register snd_wr, z80_ack_wr and z80_iack, and act only on their rising edges (input high now, low in the previous cycle); a held-high strobe SHALL count as exactly one event.
REQ-014 On a snd_wr rising edge at cycle N, the block SHALL capture cpu_din into latch_dout and SHALL show pending=1 from cycle N+1.
REQ-015 If pending=1 when a snd_wr edge occurs, the block SHALL overwrite the latch and SHALL set overrun=1; overrun SHALL clear only on reset.
REQ-016 On a z80_ack_wr rising edge, the block SHALL clear pending from the next cycle; latch_dout SHALL remain unchanged.
REQ-017 When a snd_wr edge and a z80_ack_wr edge occur in the same cycle, the write SHALL win: the latch updates, pending=1, overrun is set if pending was already 1, and the ack is discarded.
REQ-018 The block SHALL pass ym_irq_n through a two-flop synchroniser to produce ym_s (active-high); a level change at input edge N SHALL appear in ym_s after edge N+2.
REQ-019 The block SHALL compute the combinational vector as {2'b11, ~pending, ~ym_s, 4'b1111}: 0xFF when idle, 0xDF when pending only (RST 18h), 0xEF when YM only (RST 28h), 0xCF when both.
REQ-020 The block SHALL drive z80_int_n = ~(pending | ym_s), combinationally from registered state, with no additional latency.
REQ-021 On a z80_iack rising edge, the block SHALL freeze the current vector into vector_dout and SHALL hold it until z80_iack falls; while z80_iack is low, vector_dout SHALL track the live vector one cycle late.
REQ-022 Acknowledging the interrupt via z80_iack SHALL NOT clear pending or the YM request; only z80_ack_wr and the YM chip itself clear their respective requests.
REQ-023 A change of pending or ym_s during a held z80_iack SHALL NOT change vector_dout, but SHALL change z80_int_n.

Reset
REQ-024 While reset=1, the block SHALL force latch_dout=0x00, pending=0, overrun=0, vector_dout=0xFF, z80_int_n=1, both synchroniser flops to "no irq", and all edge-detect history registers to 0.
REQ-025 A strobe that is already high when reset deasserts SHALL NOT generate an event until it falls and rises again.
REQ-026 Reset asserted mid-handshake SHALL discard the pending command and any frozen vector with no residual INT.

Verification
REQ-027 Single write: snd_wr high for 3 cycles with cpu_din=0x5A -> one event; latch_dout=0x5A, pending=1, z80_int_n=0, vector=0xDF; overrun stays 0.
REQ-028 Ack: after REQ-027, pulse z80_ack_wr -> pending=0, z80_int_n=1 the next cycle, latch_dout still 0x5A.
REQ-029 Overrun and collision: write 0x11, then write 0x22 in the same cycle as an ack edge -> latch_dout=0x22, pending=1, overrun=1.
REQ-030 YM combine: ym_irq_n low with pending=1 -> after 2 edges vector=0xCF; on ack the vector becomes 0xEF and z80_int_n stays 0; when ym_irq_n goes high, z80_int_n=1 two cycles later.
REQ-031 Vector freeze: z80_iack rises with vector=0xDF, then ack occurs during iack -> vector_dout holds 0xDF until iack falls, then reads 0xFF.
REQ-032 Reset: assert reset with pending=1, overrun=1 and snd_wr held high -> all outputs at reset values; after reset release with snd_wr still high -> no capture.
